iotdf_param_filter: RTL

//  Parametrised next-generation IoT data filter. Assembles IN_W-bit beats into DATA_W-bit words,

---
 rtl/iotdf_param_filter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/iotdf_param_filter.sv
// iotdf_param_filter: IoT batch data filter.
// Shifts IN_W-bit beats MSB-first into DATA_W-bit words, groups N_WORDS words
// into a batch and reports Max/Min/Avg/Extract/Exclude/PeakMax/PeakMin results.
// Function select and range bounds are captured on the first beat of each batch.
module iotdf_param_filter #(
  parameter int DATA_W  = 128,
  parameter int IN_W    = 8,
  parameter int N_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [IN_W-1:0]   iot_in,
  input  logic [2:0]        fn_sel,
  input  logic [DATA_W-1:0] ext_lo,
  input  logic [DATA_W-1:0] ext_hi,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] iot_out
);

  localparam int BEATS = DATA_W / IN_W;
  localparam int LOG_N = $clog2(N_WORDS);
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SUM_W = DATA_W + LOG_N;

  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);
  localparam logic [LOG_N-1:0] LAST_WORD = LOG_N'(N_WORDS - 1);

  localparam logic [2:0] FN_MAX  = 3'd1;
  localparam logic [2:0] FN_MIN  = 3'd2;
  localparam logic [2:0] FN_AVG  = 3'd3;
  localparam logic [2:0] FN_EXT  = 3'd4;
  localparam logic [2:0] FN_EXC  = 3'd5;
  localparam logic [2:0] FN_PMAX = 3'd6;
  localparam logic [2:0] FN_PMIN = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [BC_W-1:0]   beat_cnt;
  logic [LOG_N-1:0]  word_cnt;
  logic [DATA_W-1:0] word_r;
  logic [2:0]        fn_r;
  logic [DATA_W-1:0] lo_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] run_min;
  logic [SUM_W-1:0]  sum_r;
  logic [DATA_W-1:0] peak_r;
  logic              peak_ok;
  logic [2:0]        prev_fn;
  logic              valid_r;
  logic [DATA_W-1:0] out_r;

  logic              accept;
  logic              first_beat;
  logic              first_word;
  logic              word_done;
  logic              batch_done;
  logic [2:0]        eff_fn;
  logic [DATA_W-1:0] eff_lo;
  logic [DATA_W-1:0] eff_hi;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] max_new;
  logic [DATA_W-1:0] min_new;
  logic [SUM_W-1:0]  sum_new;
  logic              history;
  logic              fire;
  logic [DATA_W-1:0] res;

  // Handshake, word assembly and running batch statistics for the current beat
  always_comb begin
    accept     = in_en & (state != S_FLUSH);
    first_beat = (beat_cnt == {BC_W{1'b0}}) && (word_cnt == {LOG_N{1'b0}});
    first_word = (word_cnt == {LOG_N{1'b0}});
    word_done  = accept && (beat_cnt == LAST_BEAT);
    batch_done = word_done && (word_cnt == LAST_WORD);
    // The first beat of a batch uses the live selectors, later beats the latched ones
    eff_fn     = first_beat ? fn_sel : fn_r;
    eff_lo     = first_beat ? ext_lo : lo_r;
    eff_hi     = first_beat ? ext_hi : hi_r;
    w          = (word_r << IN_W) | DATA_W'(iot_in);
    if (first_word) begin
      max_new = w;
      min_new = w;
      sum_new = {{LOG_N{1'b0}}, w};
    end else begin
      max_new = (w > run_max) ? w : run_max;
      min_new = (w < run_min) ? w : run_min;
      sum_new = sum_r + {{LOG_N{1'b0}}, w};
    end
    history = peak_ok && (eff_fn == prev_fn);
  end

  // Result selection: which function reports and with what value on this beat
  always_comb begin
    fire = 1'b0;
    res  = {DATA_W{1'b0}};
    case (eff_fn)
      FN_MAX: begin
        fire = batch_done;
        res  = max_new;
      end
      FN_MIN: begin
        fire = batch_done;
        res  = min_new;
      end
      FN_AVG: begin
        fire = batch_done;
        res  = sum_new[SUM_W-1:LOG_N];
      end
      FN_EXT: begin
        fire = word_done && (eff_lo < w) && (w < eff_hi);
        res  = w;
      end
      FN_EXC: begin
        fire = word_done && ((w < eff_lo) || (w > eff_hi));
        res  = w;
      end
      FN_PMAX: begin
        fire = batch_done && (!history || (max_new > peak_r));
        res  = max_new;
      end
      FN_PMIN: begin
        fire = batch_done && (!history || (min_new < peak_r));
        res  = min_new;
      end
      default: begin
        fire = 1'b0;
        res  = {DATA_W{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: a batch runs IDLE -> ACC -> FLUSH for one cycle -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (batch_done) begin
          state_next = S_FLUSH;
        end else if (accept) begin
          state_next = S_ACC;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ACC: begin
        if (batch_done) begin
          state_next = S_FLUSH;
        end else begin
          state_next = S_ACC;
        end
      end
      S_FLUSH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM outputs: the source is stalled only during the flush cycle
  always_comb begin
    if (state == S_FLUSH) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // Beat/word counters, shift register and per-batch selector capture
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= {BC_W{1'b0}};
      word_cnt <= {LOG_N{1'b0}};
      word_r   <= {DATA_W{1'b0}};
      fn_r     <= 3'd0;
      lo_r     <= {DATA_W{1'b0}};
      hi_r     <= {DATA_W{1'b0}};
    end else if (accept) begin
      word_r <= w;
      if (first_beat) begin
        fn_r <= fn_sel;
        lo_r <= ext_lo;
        hi_r <= ext_hi;
      end
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= {BC_W{1'b0}};
        if (word_cnt == LAST_WORD) begin
          word_cnt <= {LOG_N{1'b0}};
        end else begin
          word_cnt <= word_cnt + LOG_N'(1);
        end
      end else begin
        beat_cnt <= beat_cnt + BC_W'(1);
      end
    end
  end

  // Running max/min/sum, restarted by the first word of every batch
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max <= {DATA_W{1'b0}};
      run_min <= {DATA_W{1'b0}};
      sum_r   <= {SUM_W{1'b0}};
    end else if (word_done) begin
      run_max <= max_new;
      run_min <= min_new;
      sum_r   <= sum_new;
    end
  end

  // Peak history; only survives consecutive peak batches of the same function
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_r  <= {DATA_W{1'b0}};
      peak_ok <= 1'b0;
      prev_fn <= 3'd0;
    end else if (batch_done) begin
      prev_fn <= eff_fn;
      if ((eff_fn == FN_PMAX) || (eff_fn == FN_PMIN)) begin
        peak_ok <= 1'b1;
        if (fire) begin
          peak_r <= res;
        end
      end else begin
        peak_ok <= 1'b0;
      end
    end
  end

  // Registered result: one-cycle valid pulse, data held until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      out_r   <= {DATA_W{1'b0}};
    end else begin
      valid_r <= fire;
      if (fire) begin
        out_r <= res;
      end
    end
  end

  assign valid   = valid_r;
  assign iot_out = out_r;

endmodule
